// File: rtl/decode_queue_if.sv
// rtl/decode_queue_if.sv - decode queue type definitions and fetch/dispatch interface
// Format and operation encodings shared by the decode queue and its clients.

package decode_queue_pkg;

    typedef enum logic [2:0] {
        TY_R = 3'd0,
        TY_I = 3'd1,
        TY_S = 3'd2,
        TY_B = 3'd3,
        TY_U = 3'd4,
        TY_J = 3'd5
    } inst_ty_t;

    typedef enum logic [5:0] {
        OPT_NOP,
        OPT_LUI, OPT_AUIPC, OPT_JAL, OPT_JALR,
        OPT_BEQ, OPT_BNE, OPT_BLT, OPT_BGE, OPT_BLTU, OPT_BGEU,
        OPT_LB, OPT_LH, OPT_LW, OPT_LBU, OPT_LHU,
        OPT_SB, OPT_SH, OPT_SW,
        OPT_ADDI, OPT_SLTI, OPT_SLTIU, OPT_XORI, OPT_ORI, OPT_ANDI,
        OPT_SLLI, OPT_SRLI, OPT_SRAI,
        OPT_ADD, OPT_SUB, OPT_SLL, OPT_SLT, OPT_SLTU,
        OPT_XOR, OPT_SRL, OPT_SRA, OPT_OR, OPT_AND
    } inst_opt_t;

endpackage

interface decode_queue_if;

    logic                        in_valid;
    logic                        in_ready;
    logic [31:0]                 in_inst;
    logic [31:0]                 in_pc;

    logic                        out_valid;
    logic                        out_ready;
    decode_queue_pkg::inst_ty_t  out_ty;
    decode_queue_pkg::inst_opt_t out_opt;
    logic [4:0]                  out_rd;
    logic [4:0]                  out_rs1;
    logic [4:0]                  out_rs2;
    logic                        out_use_rs1;
    logic                        out_use_rs2;
    logic [31:0]                 out_imm;
    logic [31:0]                 out_pc;
    logic [31:0]                 out_target;
    logic                        out_is_ls;
    logic                        out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_ty, out_opt, out_rd, out_rs1, out_rs2,
               out_use_rs1, out_use_rs2, out_imm, out_pc, out_target,
               out_is_ls, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_ty, out_opt, out_rd, out_rs1, out_rs2,
               out_use_rs1, out_use_rs2, out_imm, out_pc, out_target,
               out_is_ls, out_illegal
    );

endinterface

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - circular instruction queue with RV32I decode into a registered dispatch slot
// Head entry is decoded combinationally and captured into the out_* slot when the slot frees up.

module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int IDX_W         = 3,
    parameter bit CHECK_ILLEGAL = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rdy,
    input  logic          flush,
    decode_queue_if.slave bus
);

    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6f;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;

    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic push;
    logic load;

    assign bus.in_ready = rdy && (count != FULL_CNT);
    assign push = rdy && !flush && bus.in_valid && bus.in_ready;
    assign load = rdy && !flush && (count != '0) && (!bus.out_valid || bus.out_ready);

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[tail] <= bus.in_inst;
            pc_mem[tail]   <= bus.in_pc;
        end
    end

    logic [31:0] h_inst;
    logic [31:0] h_pc;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_sh;

    assign h_inst = inst_mem[head];
    assign h_pc   = pc_mem[head];
    assign opc    = h_inst[6:0];
    assign f3     = h_inst[14:12];
    assign f7     = h_inst[31:25];

    assign imm_i  = {{20{h_inst[31]}}, h_inst[31:20]};
    assign imm_s  = {{20{h_inst[31]}}, h_inst[31:25], h_inst[11:7]};
    assign imm_b  = {{19{h_inst[31]}}, h_inst[31], h_inst[7], h_inst[30:25], h_inst[11:8], 1'b0};
    assign imm_u  = {h_inst[31:12], 12'b0};
    assign imm_j  = {{11{h_inst[31]}}, h_inst[31], h_inst[19:12], h_inst[20], h_inst[30:21], 1'b0};
    assign imm_sh = {27'b0, h_inst[24:20]};

    inst_ty_t    d_ty;
    inst_opt_t   d_opt;
    logic [31:0] d_imm;
    logic        d_ls;
    logic        wr_rd;
    logic        rd_rs1;
    logic        rd_rs2;
    logic        bad;
    logic        alt;

    // Classify the head entry; field gating for unused registers happens below.
    always_comb begin
        d_ty   = TY_R;
        d_opt  = OPT_NOP;
        d_imm  = '0;
        d_ls   = 1'b0;
        wr_rd  = 1'b0;
        rd_rs1 = 1'b0;
        rd_rs2 = 1'b0;
        bad    = 1'b0;
        alt    = (f7 == 7'h20);
        if (h_inst[1:0] != 2'b11) begin
            bad = 1'b1;
        end else begin
            case (opc)
                OPC_LUI: begin
                    d_ty = TY_U; d_opt = OPT_LUI; d_imm = imm_u; wr_rd = 1'b1;
                end
                OPC_AUIPC: begin
                    d_ty = TY_U; d_opt = OPT_AUIPC; d_imm = imm_u; wr_rd = 1'b1;
                end
                OPC_JAL: begin
                    d_ty = TY_J; d_opt = OPT_JAL; d_imm = imm_j; wr_rd = 1'b1;
                end
                OPC_JALR: begin
                    d_ty = TY_I; d_opt = OPT_JALR; d_imm = imm_i; wr_rd = 1'b1; rd_rs1 = 1'b1;
                    bad = (f3 != 3'd0);
                end
                OPC_BRANCH: begin
                    d_ty = TY_B; d_imm = imm_b; rd_rs1 = 1'b1; rd_rs2 = 1'b1;
                    case (f3)
                        3'd0:    d_opt = OPT_BEQ;
                        3'd1:    d_opt = OPT_BNE;
                        3'd4:    d_opt = OPT_BLT;
                        3'd5:    d_opt = OPT_BGE;
                        3'd6:    d_opt = OPT_BLTU;
                        3'd7:    d_opt = OPT_BGEU;
                        default: bad = 1'b1;
                    endcase
                end
                OPC_LOAD: begin
                    d_ty = TY_I; d_imm = imm_i; wr_rd = 1'b1; rd_rs1 = 1'b1; d_ls = 1'b1;
                    case (f3)
                        3'd0:    d_opt = OPT_LB;
                        3'd1:    d_opt = OPT_LH;
                        3'd2:    d_opt = OPT_LW;
                        3'd4:    d_opt = OPT_LBU;
                        3'd5:    d_opt = OPT_LHU;
                        default: bad = 1'b1;
                    endcase
                end
                OPC_STORE: begin
                    d_ty = TY_S; d_imm = imm_s; rd_rs1 = 1'b1; rd_rs2 = 1'b1; d_ls = 1'b1;
                    case (f3)
                        3'd0:    d_opt = OPT_SB;
                        3'd1:    d_opt = OPT_SH;
                        3'd2:    d_opt = OPT_SW;
                        default: bad = 1'b1;
                    endcase
                end
                OPC_OPIMM: begin
                    d_ty = TY_I; d_imm = imm_i; wr_rd = 1'b1; rd_rs1 = 1'b1;
                    case (f3)
                        3'd0: d_opt = OPT_ADDI;
                        3'd1: begin
                            d_opt = OPT_SLLI; d_imm = imm_sh; bad = (f7 != 7'h00);
                        end
                        3'd2: d_opt = OPT_SLTI;
                        3'd3: d_opt = OPT_SLTIU;
                        3'd4: d_opt = OPT_XORI;
                        3'd5: begin
                            d_opt = alt ? OPT_SRAI : OPT_SRLI;
                            d_imm = imm_sh;
                            bad   = (f7 != 7'h00) && !alt;
                        end
                        3'd6: d_opt = OPT_ORI;
                        default: d_opt = OPT_ANDI;
                    endcase
                end
                OPC_OP: begin
                    d_ty = TY_R; wr_rd = 1'b1; rd_rs1 = 1'b1; rd_rs2 = 1'b1;
                    // fun7 0x20 is only meaningful for SUB and SRA.
                    bad = (f7 != 7'h00) && !(alt && (f3 == 3'd0 || f3 == 3'd5));
                    case (f3)
                        3'd0:    d_opt = alt ? OPT_SUB : OPT_ADD;
                        3'd1:    d_opt = OPT_SLL;
                        3'd2:    d_opt = OPT_SLT;
                        3'd3:    d_opt = OPT_SLTU;
                        3'd4:    d_opt = OPT_XOR;
                        3'd5:    d_opt = alt ? OPT_SRA : OPT_SRL;
                        3'd6:    d_opt = OPT_OR;
                        default: d_opt = OPT_AND;
                    endcase
                end
                default: bad = 1'b1;
            endcase
        end
    end

    inst_ty_t    s_ty;
    inst_opt_t   s_opt;
    logic [4:0]  s_rd;
    logic [4:0]  s_rs1;
    logic [4:0]  s_rs2;
    logic [31:0] s_imm;
    logic [31:0] s_target;

    assign s_ty     = bad ? TY_R : d_ty;
    assign s_opt    = bad ? OPT_NOP : d_opt;
    assign s_rd     = (wr_rd && !bad) ? h_inst[11:7] : 5'd0;
    assign s_rs1    = (rd_rs1 && !bad) ? h_inst[19:15] : 5'd0;
    assign s_rs2    = (rd_rs2 && !bad) ? h_inst[24:20] : 5'd0;
    assign s_imm    = bad ? 32'd0 : d_imm;
    assign s_target = h_pc + s_imm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            bus.out_valid   <= 1'b0;
            bus.out_ty      <= TY_R;
            bus.out_opt     <= OPT_NOP;
            bus.out_rd      <= '0;
            bus.out_rs1     <= '0;
            bus.out_rs2     <= '0;
            bus.out_use_rs1 <= 1'b0;
            bus.out_use_rs2 <= 1'b0;
            bus.out_imm     <= '0;
            bus.out_pc      <= '0;
            bus.out_target  <= '0;
            bus.out_is_ls   <= 1'b0;
            bus.out_illegal <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                // Slot data is left in place; only the valid bit and pointers drop.
                head          <= '0;
                tail          <= '0;
                count         <= '0;
                bus.out_valid <= 1'b0;
            end else begin
                if (push) begin
                    tail <= tail + 1'b1;
                end
                if (load) begin
                    head            <= head + 1'b1;
                    bus.out_valid   <= 1'b1;
                    bus.out_ty      <= s_ty;
                    bus.out_opt     <= s_opt;
                    bus.out_rd      <= s_rd;
                    bus.out_rs1     <= s_rs1;
                    bus.out_rs2     <= s_rs2;
                    bus.out_use_rs1 <= rd_rs1 && !bad;
                    bus.out_use_rs2 <= rd_rs2 && !bad;
                    bus.out_imm     <= s_imm;
                    bus.out_pc      <= h_pc;
                    bus.out_target  <= s_target;
                    bus.out_is_ls   <= d_ls && !bad;
                    bus.out_illegal <= CHECK_ILLEGAL && bad;
                end else if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                end
                case ({push, load})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor to the combinational RV32I decoder.
- Buffers fetched instructions from the IFetch unit in a DEPTH-entry circular queue and decodes the head entry into a registered output slot.
- Uses a valid/ready handshake to dispatch and supports pipeline flush and a global ready-stall.
- Adds behaviour the plain decoder lacks: illegal-instruction detection, register-usage flags, shamt immediates and a precomputed PC-relative target.

Parameters:
DEPTH, 8, queue entries; power of two, at least 2
IDX_W, 3, log2(DEPTH); pointer width
CHECK_ILLEGAL, 1, 1 = flag illegal encodings; 0 = out_illegal tied to 0

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
rdy  in  1  global enable; when 0 all state holds
flush  in  1  discard queue and output slot (mispredict or exception)
in_valid  in  1  fetch presents an instruction
in_ready  out  1  queue can accept; equals rdy && (count < DEPTH)
in_inst  in  32  instruction word
in_pc  in  32  PC of in_inst
out_valid  out  1  decoded slot holds an instruction
out_ready  in  1  dispatch consumes the slot
out_ty  out  INST_TY width  instruction format (R/I/S/B/U/J)
out_opt  out  INST_OPT width  operation code from utils.v
out_rd  out  5  destination register; 0 when there is no write
out_rs1  out  5  source 1; 0 when unused
out_rs2  out  5  source 2; 0 when unused
out_use_rs1  out  1  rs1 is read
out_use_rs2  out  1  rs2 is read
out_imm  out  32  immediate
out_pc  out  32  instruction PC
out_target  out  32  out_pc + out_imm (meaningful for JAL and B-type)
out_is_ls  out  1  load or store
out_illegal  out  1  unsupported encoding

Behaviour:
- Reset (asynchronous, rst=1):
  - head = tail = count = 0; out_valid = 0.
  - All out_* data fields = 0.
  - in_ready follows count, so it is 1 once rst is released and rdy=1.
- rdy=0: no push, no pop, no flush effect; all registers hold; in_ready = 0.
- Push: on a clk edge with rdy && in_valid && in_ready, write {inst, pc} at tail; tail increments and wraps modulo DEPTH.
- Pop:
  - Slot load condition is load = rdy && (count != 0) && (!out_valid || out_ready).
  - On load, the head entry is decoded and registered into the out_* fields, out_valid = 1, and head increments with wrap.
  - When out_ready && out_valid && !load, out_valid goes to 0.
- Simultaneous push and pop: count is unchanged. A full queue does not accept in the same cycle as a pop, because in_ready is count-based and has no pass-through.
- Latency: an instruction pushed at edge t is visible with out_valid=1 after edge t+1, so minimum latency is 2 cycles. One instruction per cycle is sustained when out_ready is held at 1.
- Flush (rdy=1):
  - At the next edge head = tail = count = 0 and out_valid = 0.
  - Flush overrides push and pop in the same cycle.
  - It does not clear the out_* data fields.
- Order: FIFO, no reordering.
- Decode (combinational from the head entry, registered on load):
  - Opcode 0x37 LUI: U-type; 0x17 AUIPC: U-type.
  - Opcode 0x6f JAL: J-type, use_rs1 = use_rs2 = 0.
  - Opcode 0x67 JALR: I-type; fun3 != 0 is illegal.
  - Opcode 0x63 branches: B-type, rd = 0; fun3 of 2 or 3 is illegal.
  - Opcode 0x03 loads: I-type, is_ls = 1; fun3 of 3, 6 or 7 is illegal.
  - Opcode 0x23 stores: S-type, rd = 0, is_ls = 1; fun3 > 2 is illegal.
  - Opcode 0x13 OP-IMM: every op is I-type, including SLTI and SLTIU.
  - SLLI/SRLI/SRAI: imm = {27'b0, inst[24:20]}. fun7 must be 0x00, or 0x20 for SRAI; anything else is illegal.
  - Opcode 0x33 OP: R-type. fun7 must be 0x00, or 0x20 for SUB and SRA; anything else is illegal.
  - Any other opcode, or inst[1:0] != 2'b11, is illegal.
- Illegal entries:
  - ty = R, opt = OPT_NOP, rd = rs1 = rs2 = 0, use flags = 0, is_ls = 0.
  - The entry is still delivered with out_valid = 1 and out_illegal = 1.
- Immediates: standard RV32I sign extension per format. out_target = out_pc + out_imm, 32-bit, wraps modulo 2^32.

Test Plan:
- Reset mid-stream: push 3 entries, assert rst -> out_valid = 0 and count = 0 immediately (asynchronous); after release the first push 0x00500093 at pc 0x0 gives ADDI, rd = 1, rs1 = 0, imm = 5.
- Fill and backpressure with DEPTH = 8 and out_ready = 0: push 9 instructions -> 8 queued plus 1 in the slot; in_ready = 0 after the 9th; draining yields all 9 in order.
- Stream: push back-to-back with out_ready = 1 -> out_valid held at 1 and one instruction per cycle after the 2-cycle latency; pointers wrap past index 7 with no loss.
- Branch target: 0xFE000EE3 (BEQ x0,x0,-4) at pc 0x100 -> ty = B, rd = 0, imm = 0xFFFFFFFC, target = 0x000000FC.
- Illegal and shift: 0x4000D093 -> SRAI? no: fun7 = 0x20, fun3 = 5, opcode 0x13 -> SRAI, imm = 0. 0x0000007F -> illegal = 1, opt = OPT_NOP. 0x0020A013 (SLTI) -> ty = I, imm = 2.
- Flush with simultaneous push and rdy gating: flush = 1 and in_valid = 1 in the same cycle -> queue empty and out_valid = 0 next cycle. With rdy = 0 for 3 cycles all outputs are frozen and in_ready = 0.
